// File: rtl/thermo_slew_encoder_pkg.sv
// Shared types and helpers for the thermometer slew encoder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
//
// Contents: thermo_state_t FSM encoding, to_thermo() level-to-thermometer map.
package thermo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } thermo_state_t;

  // Widest binary level the helper handles; callers zero-extend into it and
  // truncate the result down to their own 2**A_WIDTH-1 bits.
  localparam int MAX_A_WIDTH  = 8;
  localparam int THERMO_MAX_W = (1 << MAX_A_WIDTH) - 1;

  // Bit i of the result is set when i < lvl. Bits at or above the
  // 2**a_width-1 thermometer width are always cleared.
  function automatic logic [THERMO_MAX_W-1:0] to_thermo(
    input logic [MAX_A_WIDTH-1:0] lvl,
    input int                     a_width
  );
    logic [THERMO_MAX_W-1:0] res;
    res = '0;
    for (int i = 0; i < THERMO_MAX_W; i++) begin
      res[i] = (i < ((1 << a_width) - 1)) && (i < int'(lvl));
    end
    return res;
  endfunction

endpackage

// File: rtl/thermo_slew_encoder_step_timer.sv
// Modulo-STEP_DIV step counter pacing the slew ramp.
// Latency: tick is combinational from the count; it is high in the last cycle of each period.
// Backpressure: none; counts only while en is high, clr has priority.
//
// Ports: clk, rst (sync, active-high), clr (restart period at 0),
//        en (advance count), tick (count == STEP_DIV-1 while enabled).
module step_timer
  import thermo_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // A single-state counter still needs one flop to exist.
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/thermo_slew_encoder.sv
// Registered binary-to-thermometer encoder with direct jump or one-segment-per-STEP_DIV slew.
// Latency: direct mode 1 cycle; slew mode k*STEP_DIV cycles for a k-step move.
// Backpressure: a_ready is low while a ramp runs and during reset; targets offered then are ignored.
//
// Ports: clk, rst (sync, active-high); a_in/a_valid/a_ready/mode target handshake;
//        b_out thermometer code, level binary level, busy ramp active, done arrival pulse.
module thermo_slew_encoder
  import thermo_pkg::*;
#(
  parameter  int A_WIDTH  = 3,
  parameter  int STEP_DIV = 4,
  localparam int B_WIDTH  = (1 << A_WIDTH) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] a_in,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic               mode,
  output logic [B_WIDTH-1:0] b_out,
  output logic [A_WIDTH-1:0] level,
  output logic               busy,
  output logic               done
);

  thermo_state_t      state_q,  state_d;
  logic [A_WIDTH-1:0] level_q,  level_d;
  logic [A_WIDTH-1:0] target_q, target_d;
  logic               mode_q,   mode_d;
  logic [B_WIDTH-1:0] b_out_q,  b_out_d;
  logic               done_q,   done_d;

  logic accept;
  logic tick;

  assign a_ready = (state_q == IDLE) && !rst;
  assign accept  = a_valid && a_ready;

  assign b_out = b_out_q;
  assign level = level_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

  // Counter restarts on every accept so the first step lands exactly
  // STEP_DIV edges later; it only runs while a ramp is active.
  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = a_in;
          mode_d   = mode;
          if (!mode || (a_in == level_q)) begin
            level_d = a_in;
            done_d  = 1'b1;
          end else if (a_in > level_q) begin
            state_d = RAMP_UP;
          end else begin
            state_d = RAMP_DOWN;
          end
        end
      end

      // Ramp states are only entered with mode_q set; direction is fixed by
      // the target so the level can never step past either end of its range.
      RAMP_UP: begin
        if (tick && mode_q) begin
          level_d = level_q + A_WIDTH'(1);
          if (level_d == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      RAMP_DOWN: begin
        if (tick && mode_q) begin
          level_d = level_q - A_WIDTH'(1);
          if (level_d == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Decoded from the next level so b_out and level change on the same edge.
    b_out_d = B_WIDTH'(to_thermo(MAX_A_WIDTH'(level_d), A_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      level_q  <= '0;
      target_q <= '0;
      mode_q   <= 1'b0;
      b_out_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      b_out_q  <= b_out_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_thermo_slew_encoder.sv
// Directed bench for thermo_slew_encoder: default (3,4) instance plus a (4,1) corner instance.
// Inputs change and outputs are sampled on the falling clock edge.
// Every check is an immediate assertion against a hand-derived expectation.
module tb_thermo_slew_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: A_WIDTH=3, STEP_DIV=4
  logic [2:0] a_in_a    = 3'd5;
  logic       a_valid_a = 1'b1;
  logic       mode_a    = 1'b0;
  logic       a_ready_a;
  logic [6:0] b_out_a;
  logic [2:0] level_a;
  logic       busy_a;
  logic       done_a;

  // Instance B: A_WIDTH=4, STEP_DIV=1
  logic [3:0]  a_in_b    = 4'd0;
  logic        a_valid_b = 1'b0;
  logic        mode_b    = 1'b0;
  logic        a_ready_b;
  logic [14:0] b_out_b;
  logic [3:0]  level_b;
  logic        busy_b;
  logic        done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  thermo_slew_encoder #(.A_WIDTH(3), .STEP_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .a_in(a_in_a), .a_valid(a_valid_a), .a_ready(a_ready_a),
    .mode(mode_a), .b_out(b_out_a), .level(level_a), .busy(busy_a), .done(done_a)
  );

  thermo_slew_encoder #(.A_WIDTH(4), .STEP_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .a_in(a_in_b), .a_valid(a_valid_b), .a_ready(a_ready_b),
    .mode(mode_b), .b_out(b_out_b), .level(level_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] therm(input int l);
    return (32'd1 << l) - 32'd1;
  endfunction

  initial begin
    @(negedge clk);

    // Reset held 3 cycles with a target offered
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_b_out", 32'(b_out_a), 32'h00);
      chk("rst_a_ready", 32'(a_ready_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rst_release_a_ready", 32'(a_ready_a), 32'd1);
    chk("rst_release_level", 32'(level_a), 32'd0);

    // Direct mode: 5 then 6 back to back
    step();
    chk("direct5_b_out", 32'(b_out_a), 32'h1f);
    chk("direct5_done", 32'(done_a), 32'd1);
    chk("direct5_a_ready", 32'(a_ready_a), 32'd1);
    a_in_a = 3'd6;
    step();
    chk("direct6_b_out", 32'(b_out_a), 32'h3f);
    chk("direct6_done", 32'(done_a), 32'd1);
    a_valid_a = 1'b0;
    step();
    chk("direct_idle_done", 32'(done_a), 32'd0);
    chk("direct_idle_b_out", 32'(b_out_a), 32'h3f);

    // Back to 0 directly
    a_valid_a = 1'b1; a_in_a = 3'd0; mode_a = 1'b0;
    step();
    chk("direct0_b_out", 32'(b_out_a), 32'h00);
    chk("direct0_done", 32'(done_a), 32'd1);

    // Slew up 0 -> 5, with a stray target 7 offered during the ramp
    a_in_a = 3'd5; mode_a = 1'b1;
    step();
    chk("up_start_busy", 32'(busy_a), 32'd1);
    chk("up_start_a_ready", 32'(a_ready_a), 32'd0);
    chk("up_start_b_out", 32'(b_out_a), 32'h00);
    chk("up_start_done", 32'(done_a), 32'd0);
    a_in_a = 3'd7; mode_a = 1'b0;  // a_valid stays high: must be ignored
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("up_level", 32'(level_a), 32'(j / 4));
      chk("up_b_out", 32'(b_out_a), therm(j / 4));
      chk("up_busy", 32'(busy_a), (j < 20) ? 32'd1 : 32'd0);
      chk("up_a_ready", 32'(a_ready_a), (j < 20) ? 32'd0 : 32'd1);
      chk("up_done", 32'(done_a), (j == 20) ? 32'd1 : 32'd0);
    end
    a_valid_a = 1'b0;
    step();
    chk("up_after_level", 32'(level_a), 32'd5);
    chk("up_after_done", 32'(done_a), 32'd0);

    // Slew down 6 -> 1
    a_valid_a = 1'b1; a_in_a = 3'd6; mode_a = 1'b0;
    step();
    chk("down_pre_b_out", 32'(b_out_a), 32'h3f);
    a_in_a = 3'd1; mode_a = 1'b1;
    step();
    a_valid_a = 1'b0;
    chk("down_start_busy", 32'(busy_a), 32'd1);
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("down_level", 32'(level_a), 32'(6 - j / 4));
      chk("down_b_out", 32'(b_out_a), therm(6 - j / 4));
      chk("down_done", 32'(done_a), (j == 20) ? 32'd1 : 32'd0);
    end
    chk("down_end_b_out", 32'(b_out_a), 32'h01);

    // Reset at step 2 of a ramp 1 -> 7
    a_valid_a = 1'b1; a_in_a = 3'd7; mode_a = 1'b1;
    step();
    a_valid_a = 1'b0;
    for (int j = 1; j <= 8; j++) step();
    chk("abort_pre_level", 32'(level_a), 32'd3);
    chk("abort_pre_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    step();
    chk("abort_b_out", 32'(b_out_a), 32'h00);
    chk("abort_level", 32'(level_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    step();
    chk("abort_after_done", 32'(done_a), 32'd0);

    // A_WIDTH=4, STEP_DIV=1: ramp 0 -> 15 one step per cycle
    a_valid_b = 1'b1; a_in_b = 4'd15; mode_b = 1'b1;
    step();
    a_valid_b = 1'b0;
    chk("p_start_busy", 32'(busy_b), 32'd1);
    for (int j = 1; j <= 15; j++) begin
      step();
      chk("p_level", 32'(level_b), 32'(j));
      chk("p_b_out", 32'(b_out_b), therm(j));
      chk("p_done", 32'(done_b), (j == 15) ? 32'd1 : 32'd0);
    end
    chk("p_end_b_out", 32'(b_out_b), 32'h7fff);
    chk("p_end_a_ready", 32'(a_ready_b), 32'd1);

    // Re-issue 15: zero distance completes immediately
    a_valid_b = 1'b1; a_in_b = 4'd15; mode_b = 1'b1;
    step();
    a_valid_b = 1'b0;
    chk("p_reissue_done", 32'(done_b), 32'd1);
    chk("p_reissue_b_out", 32'(b_out_b), 32'h7fff);
    chk("p_reissue_busy", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thermo_slew_encoder.md
# thermo_slew_encoder

Parametrised, registered binary-to-thermometer encoder that replaces the purely combinational comparator bank. It converts an `A_WIDTH`-bit level into a `B_WIDTH = 2**A_WIDTH - 1` bit thermometer code. It supports two modes:
- direct: the output jumps to the new level in one cycle;
- slew: the output ramps one segment per `STEP_DIV` cycles, so a segmented DAC or level-indicator downstream never sees multi-bit glitches.

It sits between the control logic that produces target levels and the segment drivers, and uses a valid/ready input handshake.

## Interface
- `A_WIDTH`, 3, binary input width; must be ≥ 1.
- `STEP_DIV`, 4, clock cycles per single-segment step in slew mode; must be ≥ 1.
- `B_WIDTH`, `2**A_WIDTH-1`, thermometer width; a localparam, not overridable.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_in` in `A_WIDTH`: target level; the source holds it stable until accepted.
- `a_valid` in 1: target present.
- `a_ready` out 1: block can accept a target.
- `mode` in 1: 0 = direct, 1 = slew; sampled only at accept.
- `b_out` out `B_WIDTH`: thermometer code, `b_out[i] = (i < level)`.
- `level` out `A_WIDTH`: current binary level.
- `busy` out 1: ramp in progress.
- `done` out 1: one-cycle pulse when `level` reaches the accepted target.

## Operation
- FSM states: IDLE, RAMP_UP, RAMP_DOWN.
- `a_ready = (state == IDLE) && !rst`.
- `busy = (state != IDLE)`.
- An accept is `a_valid && a_ready` at a rising edge. On accept, the block latches `a_in` into `target` and `mode` into `mode_q`.
- At an accept, in direct mode or when `a_in == level`:
  - `level <= a_in`;
  - state stays IDLE;
  - `done = 1` for the following cycle.
- At an accept in slew mode:
  - `a_in > level` → RAMP_UP;
  - `a_in < level` → RAMP_DOWN;
  - the step counter is cleared.
- RAMP_UP / RAMP_DOWN behaviour:
  - the step counter counts 0 … `STEP_DIV-1`;
  - on the wrap edge, `level` steps by ±1;
  - if the new `level` equals `target`, state goes to IDLE and `done = 1` for the following cycle.
- `b_out` and `level` are updated on the same edge and are never inconsistent. `b_out` is registered from the next-level value and has no decode latency relative to `level`.
- `a_valid` while busy is ignored: `a_ready` stays 0 and nothing is latched.
- `mode` and `a_in` changes while busy have no effect.
- Level arithmetic is unsigned, `A_WIDTH` bits. Stepping never wraps: ramp direction is fixed by the target, so `level` stays within 0 … `2**A_WIDTH-1`.
- Maximum level sets all `B_WIDTH` bits. Level 0 clears all bits.

## Timing
- Reset values:
  - `level = 0`, `b_out = 0`, state = IDLE, step counter = 0;
  - `busy = 0`, `done = 0`;
  - `a_ready = 0` while `rst` is high, and 1 in the first cycle after `rst` falls.
- Reset mid-ramp aborts the ramp immediately. Outputs take their reset values on the next edge, and `done` is not pulsed.
- Direct-mode latency: with an accept at edge N, `level`/`b_out` are new after edge N, `done` is high from N to N+1, and `a_ready` remains 1. Back-to-back accepts are allowed every cycle.
- Slew-mode latency for a distance of k steps:
  - the i-th step appears after edge N + i·`STEP_DIV`;
  - the final step is at N + k·`STEP_DIV`;
  - `done` is high for the cycle after that edge, and `a_ready` returns in the same cycle.
  - The next accept is possible at edge N + k·`STEP_DIV` + 1.
- `STEP_DIV = 1` gives one step per cycle.

## Structure
- Package `thermo_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} thermo_state_t`;
  - function `to_thermo`, which maps a level to a thermometer vector and is parametrised via `A_WIDTH`.
- Sub-module `step_timer` holds the `$clog2(STEP_DIV)`-bit (minimum 1-bit) modulo-`STEP_DIV` counter. It has clear and enable inputs and a `tick` output on wrap.
- Top-level instance name stays `top`-compatible: the existing bench wrapper instantiates this block with `.A_WIDTH`.

## Test plan
All cases use `A_WIDTH=3`, `STEP_DIV=4` unless noted.
- Reset:
  - Stimulus: `rst` high for 3 cycles with `a_valid = 1`.
  - Required: `b_out = 7'b0000000`, `a_ready = 0` and `done = 0` throughout; `a_ready = 1` in the first cycle after `rst` falls.
- Direct mode:
  - Stimulus: `a_in = 3'b101`, `mode = 0`.
  - Required: `b_out = 7'b0011111` after the accept edge, one `done` pulse; then `a_in = 3'b110` the next cycle gives `7'b0111111`.
- Slew up:
  - Stimulus: from 0, `a_in = 3'b101`, `mode = 1`.
  - Required: `b_out` steps `0000001`, `0000011` … `0011111` at accept+4, +8, +12, +16, +20; `done` for the cycle after +20; `busy = 1` and `a_ready = 0` in between.
- Slew down:
  - Stimulus: from 6, `a_in = 3'b001`.
  - Required: 5 descending steps, 4 cycles apart, ending at `b_out = 7'b0000001`.
- Protocol corners:
  - Stimulus: `a_valid` with `a_in = 7` during a ramp.
  - Required: ignored, and the ramp completes to the original target.
  - Stimulus: `rst` at step 2 of a ramp.
  - Required: `b_out = 0` after the next edge, with no `done`.
- Parameter corners:
  - Stimulus: `A_WIDTH=4`, `STEP_DIV=1`, `a_in = 15`.
  - Required: 15 steps in 15 cycles, ending at `b_out` = all 15 ones.
  - Stimulus: re-issuing `a_in = 15`.
  - Required: `done` next cycle, `b_out` unchanged.
